// File: rtl/par_out_if.sv
// Parallel output interface: valid/ready FIFO feeding a registered bus with setup/strobe/hold.
// Define PAR_OUT_PARITY_EN to add the registered even-parity output dpar.
module par_out_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SETUP   = 2,
  parameter int unsigned STB_LEN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       busy,
  output logic [WIDTH-1:0]           dout,
  output logic                       dstb,
  output logic                       doe,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       idle
`ifdef PAR_OUT_PARITY_EN
  ,
  output logic                       dpar
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dstb_q, dstb_d;
  logic              doe_q, doe_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic push, pop, can_start;

  // Ready depends only on registered occupancy, never on busy.
  assign din_ready = (level_q != LW'(DEPTH));
  assign push      = din_valid && din_ready;
  assign can_start = (level_q != '0) && !busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dstb_d  = dstb_q;
    doe_d   = doe_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        doe_d  = 1'b0;
        dstb_d = 1'b0;
        if (can_start) begin
          pop     = 1'b1;
          dout_d  = mem_q[rd_ptr_q];
          doe_d   = 1'b1;
          cnt_d   = CW'(SETUP - 1);
          state_d = StSetup;
        end
      end
      StSetup: begin
        dstb_d = 1'b0;
        if (cnt_q == '0) begin
          dstb_d  = 1'b1;
          cnt_d   = CW'(STB_LEN - 1);
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          dstb_d  = 1'b0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StHold: begin
        dstb_d = 1'b0;
        // Back-to-back: reload straight from HOLD without passing through IDLE.
        if (can_start) begin
          pop     = 1'b1;
          dout_d  = mem_q[rd_ptr_q];
          doe_d   = 1'b1;
          cnt_d   = CW'(SETUP - 1);
          state_d = StSetup;
        end else begin
          doe_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dout_q   <= '0;
      dstb_q   <= 1'b0;
      doe_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dstb_q  <= dstb_d;
      doe_q   <= doe_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

`ifdef PAR_OUT_PARITY_EN
  logic dpar_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dpar_q <= 1'b0;
    end else if (pop) begin
      dpar_q <= ^mem_q[rd_ptr_q];
    end
  end

  assign dpar = dpar_q;
`endif

  assign dout  = dout_q;
  assign dstb  = dstb_q;
  assign doe   = doe_q;
  assign level = level_q;
  assign idle  = (state_q == StIdle) && (level_q == '0);

endmodule
